// File: rtl/scene_pkg.sv
// Shared screen geometry, FSM state type, pixel pipeline record and default layout.
// Imported by the renderer and its scan counters.
package scene_pkg;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int COL_W       = 3;
  localparam int BLANK_GLYPH = 10;
  localparam int GLYPHS      = 11;

  localparam int DEF_NUM_MOLES  = 8;
  localparam int DEF_FRAME_BITS = 5;
  localparam int DEF_NUM_FRAMES = 2;
  localparam int DEF_SPR_W      = 16;
  localparam int DEF_SPR_H      = 20;
  localparam int DEF_MOLE_X0    = 2;
  localparam int DEF_MOLE_PITCH = 18;
  localparam int DEF_MOLE_Y     = 100;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_FONT_W     = 4;
  localparam int DEF_FONT_H     = 7;
  localparam int DEF_SCORE_X    = 58;
  localparam int DEF_SCORE_Y    = 20;
  localparam int DEF_TOTAL_X    = 58;
  localparam int DEF_TOTAL_Y    = 30;

  typedef enum logic [2:0] {ST_IDLE, ST_MOLES, ST_SCORE, ST_TOTAL, ST_DRAIN} state_t;

  typedef struct packed {
    logic       vld;
    logic       font;
    logic       clip;
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Non-decimal nibbles all render as the blank glyph.
  function automatic logic [3:0] glyph_of(input logic [3:0] d);
    return (d > 4'd9) ? 4'(BLANK_GLYPH) : d;
  endfunction
endpackage

// File: rtl/sprite_scan_counter.sv
// Column-fastest raster counter over a W x H sprite; wraps to 0,0 after the last pixel.
// Zero latency: col/row reflect the pixel being scanned this cycle; advance is the only stall.
module sprite_scan_counter
  import scene_pkg::*;
#(
  parameter int  W  = 16,
  parameter int  H  = 20,
  localparam int CW = cnt_w(W),
  localparam int RW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_pixel
);
  logic col_wrap;
  logic row_wrap;

  assign col_wrap   = (col == CW'(W - 1));
  assign row_wrap   = (row == RW'(H - 1));
  assign last_pixel = col_wrap && row_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mole_scene_renderer.sv
// Per frame_start, rasterises the mole sprites then the score and total BCD counters, one pixel per clock.
// Pixel appears 2 cycles after its ROM address; no backpressure, a frame_start while busy is dropped and flagged in overrun.
module mole_scene_renderer
  import scene_pkg::*;
#(
  parameter int               NUM_MOLES  = DEF_NUM_MOLES,
  parameter int               FRAME_BITS = DEF_FRAME_BITS,
  parameter int               NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int               SPR_W      = DEF_SPR_W,
  parameter int               SPR_H      = DEF_SPR_H,
  parameter int               MOLE_X0    = DEF_MOLE_X0,
  parameter int               MOLE_PITCH = DEF_MOLE_PITCH,
  parameter int               MOLE_Y     = DEF_MOLE_Y,
  parameter int               NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int               FONT_W     = DEF_FONT_W,
  parameter int               FONT_H     = DEF_FONT_H,
  parameter int               SCORE_X    = DEF_SCORE_X,
  parameter int               SCORE_Y    = DEF_SCORE_Y,
  parameter int               TOTAL_X    = DEF_TOTAL_X,
  parameter int               TOTAL_Y    = DEF_TOTAL_Y,
  parameter int               TRANSP_EN  = 1,
  parameter logic [COL_W-1:0] TRANSP_COL = 3'b000,
  localparam int              MA_W       = $clog2(NUM_FRAMES * SPR_W * SPR_H),
  localparam int              FA_W       = $clog2(GLYPHS * FONT_W * FONT_H)
) (
  input  logic                            CLOCK_50,
  input  logic                            resetn,
  input  logic                            frame_start,
  input  logic [NUM_MOLES*FRAME_BITS-1:0] mole_frames,
  input  logic [4*NUM_DIGITS-1:0]         score,
  input  logic [4*NUM_DIGITS-1:0]         total,
  output logic [MA_W-1:0]                 mole_rom_addr,
  input  logic [COL_W-1:0]                mole_rom_q,
  output logic [FA_W-1:0]                 font_rom_addr,
  input  logic [COL_W-1:0]                font_rom_q,
  output logic [7:0]                      x,
  output logic [6:0]                      y,
  output logic [COL_W-1:0]                colour,
  output logic                            plot,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);
  localparam int MCW = cnt_w(SPR_W);
  localparam int MRW = cnt_w(SPR_H);
  localparam int FCW = cnt_w(FONT_W);
  localparam int FRW = cnt_w(FONT_H);

  state_t                          state;
  logic [NUM_MOLES*FRAME_BITS-1:0] frames_q;
  logic [4*NUM_DIGITS-1:0]         score_q, total_q, digs;
  logic [7:0]                      obj;
  logic [1:0]                      drain_cnt;
  pix_t                            p1, p2;

  logic [MCW-1:0] m_col;
  logic [MRW-1:0] m_row;
  logic [FCW-1:0] s_col, t_col, dc;
  logic [FRW-1:0] s_row, t_row, dr;
  logic           m_last, s_last, t_last, d_last;
  logic           m_adv, s_adv, t_adv, start_pass;

  logic                  scan_vld, scan_font, obj_last, phase_last;
  logic [15:0]           scan_x, scan_y;
  logic [MA_W-1:0]       m_addr;
  logic [FA_W-1:0]       f_addr;
  logic [FRAME_BITS-1:0] f_raw;
  logic [3:0]            nib;
  logic [COL_W-1:0]      pix_q;

  assign start_pass = (state == ST_IDLE) && frame_start && !done;
  assign pix_q      = p2.font ? font_rom_q : mole_rom_q;

  sprite_scan_counter #(.W(SPR_W), .H(SPR_H)) u_mole_cnt (
    .clk(CLOCK_50), .rst_n(resetn), .start(start_pass), .advance(m_adv),
    .col(m_col), .row(m_row), .last_pixel(m_last)
  );
  sprite_scan_counter #(.W(FONT_W), .H(FONT_H)) u_score_cnt (
    .clk(CLOCK_50), .rst_n(resetn), .start(start_pass), .advance(s_adv),
    .col(s_col), .row(s_row), .last_pixel(s_last)
  );
  sprite_scan_counter #(.W(FONT_W), .H(FONT_H)) u_total_cnt (
    .clk(CLOCK_50), .rst_n(resetn), .start(start_pass), .advance(t_adv),
    .col(t_col), .row(t_row), .last_pixel(t_last)
  );

  always_comb begin
    scan_vld   = 1'b0;
    scan_font  = 1'b0;
    m_adv      = 1'b0;
    s_adv      = 1'b0;
    t_adv      = 1'b0;
    obj_last   = 1'b0;
    phase_last = 1'b0;
    scan_x     = '0;
    scan_y     = '0;
    m_addr     = '0;
    f_addr     = '0;
    f_raw      = '0;
    nib        = '0;
    digs       = score_q;
    dc         = s_col;
    dr         = s_row;
    d_last     = s_last;
    case (state)
      ST_MOLES: begin
        scan_vld   = 1'b1;
        m_adv      = 1'b1;
        f_raw      = frames_q[int'(obj)*FRAME_BITS +: FRAME_BITS];
        // Frame indices beyond the ROM contents fall back to frame 0.
        m_addr     = MA_W'(((int'(f_raw) < NUM_FRAMES) ? int'(f_raw) : 0) * SPR_W * SPR_H
                           + int'(m_row) * SPR_W + int'(m_col));
        scan_x     = 16'(MOLE_X0 + int'(obj) * MOLE_PITCH + int'(m_col));
        scan_y     = 16'(MOLE_Y + int'(m_row));
        obj_last   = (obj == 8'(NUM_MOLES - 1));
        phase_last = m_last && obj_last;
      end
      ST_SCORE, ST_TOTAL: begin
        scan_vld  = 1'b1;
        scan_font = 1'b1;
        if (state == ST_TOTAL) begin
          digs   = total_q;
          dc     = t_col;
          dr     = t_row;
          d_last = t_last;
          t_adv  = 1'b1;
        end else begin
          s_adv = 1'b1;
        end
        // obj counts digits left to right, so the most significant nibble comes first.
        nib        = digs[(NUM_DIGITS - 1 - int'(obj))*4 +: 4];
        f_addr     = FA_W'(int'(glyph_of(nib)) * FONT_W * FONT_H + int'(dr) * FONT_W + int'(dc));
        scan_x     = 16'(((state == ST_TOTAL) ? TOTAL_X : SCORE_X) + int'(obj) * (FONT_W + 1) + int'(dc));
        scan_y     = 16'(((state == ST_TOTAL) ? TOTAL_Y : SCORE_Y) + int'(dr));
        obj_last   = (obj == 8'(NUM_DIGITS - 1));
        phase_last = d_last && obj_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      frames_q      <= '0;
      score_q       <= '0;
      total_q       <= '0;
      obj           <= '0;
      drain_cnt     <= '0;
      p1            <= '0;
      p2            <= '0;
      mole_rom_addr <= '0;
      font_rom_addr <= '0;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      done   <= 1'b0;
      plot   <= 1'b0;
      colour <= '0;

      // Coordinates ride alongside the ROM access so they meet its data two edges later.
      p1.vld <= scan_vld;
      if (scan_vld) begin
        p1.font <= scan_font;
        p1.x    <= scan_x[7:0];
        p1.y    <= scan_y[6:0];
        p1.clip <= (scan_x >= 16'(SCREEN_W)) || (scan_y >= 16'(SCREEN_H));
        if (scan_font) font_rom_addr <= f_addr;
        else           mole_rom_addr <= m_addr;
      end
      p2 <= p1;

      if (p2.vld) begin
        x <= p2.x;
        y <= p2.y;
        if (!p2.clip && !((TRANSP_EN != 0) && (pix_q == TRANSP_COL))) begin
          plot   <= 1'b1;
          colour <= pix_q;
        end
      end

      if (frame_start && ((state != ST_IDLE) || done)) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_pass) begin
            frames_q <= mole_frames;
            score_q  <= score;
            total_q  <= total;
            obj      <= '0;
            busy     <= 1'b1;
            state    <= ST_MOLES;
          end
        end
        ST_MOLES: begin
          if (phase_last) begin
            obj   <= '0;
            state <= ST_SCORE;
          end else if (m_last) begin
            obj <= obj + 8'd1;
          end
        end
        ST_SCORE: begin
          if (phase_last) begin
            obj   <= '0;
            state <= ST_TOTAL;
          end else if (s_last) begin
            obj <= obj + 8'd1;
          end
        end
        ST_TOTAL: begin
          if (phase_last) begin
            obj       <= '0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else if (t_last) begin
            obj <= obj + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'd2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
